elevador_escalonador: RTL and testbench

- Call scheduler and motion sequencer for the elevator car.
- Latches active-low hall (BD) and cabin (BF) buttons for every floor into a pending-call register.
- Serves calls with a SCAN (collective) policy and drives the sobe/desce motor commands and the door.
- Tracks car position with internal travel and door timers, and replaces the purely combinational floor-to-floor decision.

---
 rtl/elevador_escalonador_if.sv | 35 +++
 rtl/elevador_escalonador.sv | 200 ++++++++++++++++++++
 tb/tb_elevador_escalonador.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevador_escalonador_if.sv
// Elevator scheduler bus: button inputs toward the scheduler and motor/door/status
// outputs back out. Optional door-obstruction input under ELEVADOR_OBSTRUCAO_EN.
interface elevador_escalonador_if #(
    parameter int NUM_ANDARES = 3,
    parameter int AW          = 2
);
    logic [NUM_ANDARES-1:0] bd_n;          // hall buttons, active low
    logic [NUM_ANDARES-1:0] bf_n;          // cabin buttons, active low
    logic                   sobe;          // motor up
    logic                   desce;         // motor down
    logic                   porta_aberta;  // door open
    logic [AW-1:0]          andar_atual;   // current floor
    logic [NUM_ANDARES-1:0] pendentes;     // pending calls
`ifdef ELEVADOR_OBSTRUCAO_EN
    logic                   obstrucao_n;   // 0 = door obstructed
`endif

    // Button/sensor side (panel or testbench)
    modport master (
`ifdef ELEVADOR_OBSTRUCAO_EN
        output obstrucao_n,
`endif
        output bd_n, bf_n,
        input  sobe, desce, porta_aberta, andar_atual, pendentes
    );

    // Scheduler side
    modport slave (
`ifdef ELEVADOR_OBSTRUCAO_EN
        input  obstrucao_n,
`endif
        input  bd_n, bf_n,
        output sobe, desce, porta_aberta, andar_atual, pendentes
    );
endinterface

// File: rtl/elevador_escalonador.sv
// Elevator call scheduler and motion sequencer (SCAN / collective policy).
// Latches hall and cabin calls, moves the car floor by floor using an internal
// travel timer, opens the door at called floors and keeps sweeping in one
// direction while calls remain that way.
// Optional: ELEVADOR_OBSTRUCAO_EN adds obstrucao_n, which holds the door open.
module elevador_escalonador #(
    parameter int NUM_ANDARES   = 3,
    parameter int AW            = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    elevador_escalonador_if.slave  bus
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Timers are loaded with N-1 and expire on the edge where they read zero,
    // so a load at edge E expires exactly N edges later.
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [AW-1:0] TOP_FLOOR   = AW'(NUM_ANDARES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          andar_q, andar_d;
    logic [NUM_ANDARES-1:0] pend_q, pend_d;
    logic                   dir_up_q, dir_up_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   sobe_q, desce_q, porta_q;

    logic [NUM_ANDARES-1:0] press;      // any button pressed this cycle
    logic [NUM_ANDARES-1:0] pend_set;   // pending calls including this cycle's presses
    logic [AW-1:0]          floor_up;   // neighbour floors, saturated at the ends
    logic [AW-1:0]          floor_down;
    logic                   door_hold;

    // Any call strictly above floor f
    function automatic logic any_above(input logic [NUM_ANDARES-1:0] p, input logic [AW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ANDARES; i++) begin
            if (p[i] && (i > int'(f))) r = 1'b1;
        end
        return r;
    endfunction

    // Any call strictly below floor f
    function automatic logic any_below(input logic [NUM_ANDARES-1:0] p, input logic [AW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ANDARES; i++) begin
            if (p[i] && (i < int'(f))) r = 1'b1;
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ANDARES; gi++) begin : g_press
            assign press[gi] = ~bus.bd_n[gi] | ~bus.bf_n[gi];
        end
    endgenerate

    assign pend_set   = pend_q | press;
    assign floor_up   = (andar_q == TOP_FLOOR) ? andar_q : andar_q + AW'(1);
    assign floor_down = (andar_q == '0)        ? andar_q : andar_q - AW'(1);

`ifdef ELEVADOR_OBSTRUCAO_EN
    assign door_hold = ~bus.obstrucao_n;
`else
    assign door_hold = 1'b0;
`endif

    // Next-state decision: call latch, SCAN direction choice, timers and position.
    // IDLE decides on the registered calls so a press leaves IDLE one edge later;
    // moving and door states also see same-edge presses so a call arriving with
    // the car is still served.
    always_comb begin
        state_d  = state_q;
        andar_d  = andar_q;
        pend_d   = pend_set;
        dir_up_d = dir_up_q;
        timer_d  = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_q[andar_q]) begin
                    state_d         = ST_DOOR_OPEN;
                    timer_d         = DOOR_LOAD;
                    pend_d[andar_q] = 1'b0;
                end else if (dir_up_q ? any_above(pend_q, andar_q) : any_below(pend_q, andar_q)) begin
                    state_d = dir_up_q ? ST_MOVE_UP : ST_MOVE_DOWN;
                    timer_d = TRAVEL_LOAD;
                end else if (dir_up_q ? any_below(pend_q, andar_q) : any_above(pend_q, andar_q)) begin
                    state_d  = dir_up_q ? ST_MOVE_DOWN : ST_MOVE_UP;
                    dir_up_d = ~dir_up_q;
                    timer_d  = TRAVEL_LOAD;
                end
            end

            ST_MOVE_UP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    andar_d = floor_up;
                    if (pend_set[floor_up]) begin
                        state_d          = ST_DOOR_OPEN;
                        timer_d          = DOOR_LOAD;
                        pend_d[floor_up] = 1'b0;
                    end else if (any_above(pend_set, floor_up)) begin
                        timer_d = TRAVEL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_MOVE_DOWN: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    andar_d = floor_down;
                    if (pend_set[floor_down]) begin
                        state_d            = ST_DOOR_OPEN;
                        timer_d            = DOOR_LOAD;
                        pend_d[floor_down] = 1'b0;
                    end else if (any_below(pend_set, floor_down)) begin
                        timer_d = TRAVEL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DOOR_OPEN: begin
                if (press[andar_q]) begin
                    // Press at the open floor is absorbed and keeps the door open
                    pend_d[andar_q] = pend_q[andar_q];
                    timer_d         = DOOR_LOAD;
                end else if (door_hold) begin
                    timer_d = DOOR_LOAD;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (dir_up_q ? any_above(pend_set, andar_q) : any_below(pend_set, andar_q)) begin
                    state_d = dir_up_q ? ST_MOVE_UP : ST_MOVE_DOWN;
                    timer_d = TRAVEL_LOAD;
                end else if (dir_up_q ? any_below(pend_set, andar_q) : any_above(pend_set, andar_q)) begin
                    state_d  = dir_up_q ? ST_MOVE_DOWN : ST_MOVE_UP;
                    dir_up_d = ~dir_up_q;
                    timer_d  = TRAVEL_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, position, calls, timer and registered command outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            andar_q  <= '0;
            pend_q   <= '0;
            dir_up_q <= 1'b1;
            timer_q  <= '0;
            sobe_q   <= 1'b0;
            desce_q  <= 1'b0;
            porta_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            andar_q  <= andar_d;
            pend_q   <= pend_d;
            dir_up_q <= dir_up_d;
            timer_q  <= timer_d;
            sobe_q   <= (state_d == ST_MOVE_UP);
            desce_q  <= (state_d == ST_MOVE_DOWN);
            porta_q  <= (state_d == ST_DOOR_OPEN);
        end
    end

    assign bus.sobe         = sobe_q;
    assign bus.desce        = desce_q;
    assign bus.porta_aberta = porta_q;
    assign bus.andar_atual  = andar_q;
    assign bus.pendentes    = pend_q;

endmodule

// File: tb/tb_elevador_escalonador.sv
// Testbench for elevador_escalonador: directed scenarios with literal
// expectations plus randomized button traffic checked every cycle against a
// behavioural model of the car (calls list, position, activity countdown).
module tb_elevador_escalonador;

    localparam int N    = 3;
    localparam int AW   = 2;
    localparam int TRAV = 8;
    localparam int DOOR = 4;

    localparam int A_IDLE   = 0;
    localparam int A_TRAVEL = 1;
    localparam int A_DOOR   = 2;

    logic clock;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    elevador_escalonador_if #(.NUM_ANDARES(N), .AW(AW)) bus ();

    elevador_escalonador #(
        .NUM_ANDARES(N), .AW(AW), .TRAVEL_CYCLES(TRAV), .DOOR_CYCLES(DOOR)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_pos;
    int  m_left;   // cycles remaining in the current trip leg or door opening
    int  m_act;
    bit  m_up;
    bit  m_calls [N];

    function automatic bit calls_toward(input bit c [N], input int p, input bit up);
        bit r;
        r = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (c[i] && (up ? (i > p) : (i < p))) r = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pos  <= 0;
            m_left <= 0;
            m_act  <= A_IDLE;
            m_up   <= 1'b1;
            for (int i = 0; i < N; i++) m_calls[i] <= 1'b0;
        end else begin
            int pos, left, act;
            bit up;
            bit calls [N];
            bit pr [N];
            pos  = m_pos;
            left = m_left;
            act  = m_act;
            up   = m_up;
            for (int i = 0; i < N; i++) begin
                calls[i] = m_calls[i];
                pr[i]    = (bus.bd_n[i] == 1'b0) || (bus.bf_n[i] == 1'b0);
            end
            case (act)
                A_IDLE: begin
                    // decide from calls already waiting, then record new presses
                    if (calls[pos]) begin
                        act = A_DOOR; left = DOOR;
                    end else if (calls_toward(calls, pos, up)) begin
                        act = A_TRAVEL; left = TRAV;
                    end else if (calls_toward(calls, pos, !up)) begin
                        act = A_TRAVEL; left = TRAV; up = !up;
                    end
                    for (int i = 0; i < N; i++) calls[i] = calls[i] | pr[i];
                    if (act == A_DOOR) calls[pos] = 1'b0;
                end
                A_TRAVEL: begin
                    for (int i = 0; i < N; i++) calls[i] = calls[i] | pr[i];
                    left = left - 1;
                    if (left == 0) begin
                        if (up && pos < N - 1) pos = pos + 1;
                        if (!up && pos > 0)    pos = pos - 1;
                        if (calls[pos]) begin
                            act = A_DOOR; left = DOOR; calls[pos] = 1'b0;
                        end else if (calls_toward(calls, pos, up)) begin
                            left = TRAV;
                        end else begin
                            act = A_IDLE;
                        end
                    end
                end
                default: begin
                    if (pr[pos]) begin
                        left = DOOR;
                        for (int i = 0; i < N; i++) if (i != pos) calls[i] = calls[i] | pr[i];
                    end else begin
                        for (int i = 0; i < N; i++) calls[i] = calls[i] | pr[i];
                        left = left - 1;
                        if (left == 0) begin
                            if (calls_toward(calls, pos, up)) begin
                                act = A_TRAVEL; left = TRAV;
                            end else if (calls_toward(calls, pos, !up)) begin
                                act = A_TRAVEL; left = TRAV; up = !up;
                            end else begin
                                act = A_IDLE;
                            end
                        end
                    end
                end
            endcase
            m_pos  <= pos;
            m_left <= left;
            m_act  <= act;
            m_up   <= up;
            for (int i = 0; i < N; i++) m_calls[i] <= calls[i];
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clock) begin
        int exp_pend;
        exp_pend = 0;
        for (int i = 0; i < N; i++) if (m_calls[i]) exp_pend = exp_pend | (1 << i);
        chk("cyc_sobe",  int'(bus.sobe),         int'(m_act == A_TRAVEL && m_up));
        chk("cyc_desce", int'(bus.desce),        int'(m_act == A_TRAVEL && !m_up));
        chk("cyc_porta", int'(bus.porta_aberta), int'(m_act == A_DOOR));
        chk("cyc_andar", int'(bus.andar_atual),  m_pos);
        chk("cyc_pend",  int'(bus.pendentes),    exp_pend);
        chk("cyc_excl",  int'(bus.sobe & bus.desce), 0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        bus.bd_n = '1;
        bus.bf_n = '1;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    // E0 = edge latching a single cabin call, E1 = edge leaving IDLE
    task automatic call_from_idle(input logic [N-1:0] bf);
        bus.bf_n = bf;
        tick();
        bus.bf_n = '1;
        tick();
    endtask

    initial begin
        reset_n  = 1'b0;
        bus.bd_n = '1;
        bus.bf_n = '1;
`ifdef ELEVADOR_OBSTRUCAO_EN
        bus.obstrucao_n = 1'b1;
`endif

        // 1: quiet after reset
        do_reset();
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("t1_quiet", int'({bus.sobe, bus.desce, bus.porta_aberta, bus.andar_atual, bus.pendentes}), 0);
        end

        // 2: call to floor 2 from floor 0
        bus.bf_n = 3'b011;
        tick();
        bus.bf_n = '1;
        chk("t2_latch", int'(bus.pendentes), 3'b100);
        chk("t2_still_idle", int'(bus.sobe), 0);
        tick();
        chk("t2_sobe_start", int'(bus.sobe), 1);
        repeat (7) tick();
        chk("t2_andar_e7", int'(bus.andar_atual), 0);
        tick();
        chk("t2_andar_e8", int'(bus.andar_atual), 1);
        chk("t2_model_pos", m_pos, 1);
        chk("t2_sobe_e8", int'(bus.sobe), 1);
        repeat (7) tick();
        chk("t2_sobe_e15", int'(bus.sobe), 1);
        tick();
        chk("t2_andar_e16", int'(bus.andar_atual), 2);
        chk("t2_sobe_e16", int'(bus.sobe), 0);
        chk("t2_porta_e16", int'(bus.porta_aberta), 1);
        chk("t2_pend_clr", int'(bus.pendentes), 0);
        repeat (3) tick();
        chk("t2_porta_e19", int'(bus.porta_aberta), 1);
        tick();
        chk("t2_closed", int'({bus.sobe, bus.desce, bus.porta_aberta}), 0);
        chk("t2_model_idle", m_act, A_IDLE);

        // 3: intermediate hall call during first travel
        do_reset();
        call_from_idle(3'b011);
        chk("t3_sobe", int'(bus.sobe), 1);
        repeat (2) tick();
        bus.bd_n = 3'b101;
        tick();
        bus.bd_n = '1;
        chk("t3_pend", int'(bus.pendentes), 3'b110);
        repeat (5) tick();
        chk("t3_stop_andar", int'(bus.andar_atual), 1);
        chk("t3_stop_porta", int'(bus.porta_aberta), 1);
        chk("t3_stop_sobe", int'(bus.sobe), 0);
        chk("t3_stop_pend", int'(bus.pendentes), 3'b100);
        repeat (3) tick();
        chk("t3_porta_last", int'(bus.porta_aberta), 1);
        tick();
        chk("t3_resume", int'({bus.sobe, bus.porta_aberta}), 2'b10);
        repeat (8) tick();
        chk("t3_arrive2", int'({bus.andar_atual, bus.porta_aberta}), 3'b101);
        chk("t3_pend_end", int'(bus.pendentes), 0);

        // 4: door open at 1 going up with calls 0 and 2
        do_reset();
        call_from_idle(3'b101);
        repeat (8) tick();
        chk("t4_at1", int'({bus.andar_atual, bus.porta_aberta}), 3'b011);
        bus.bf_n = 3'b010;
        tick();
        bus.bf_n = '1;
        chk("t4_pend", int'(bus.pendentes), 3'b101);
        repeat (3) tick();
        chk("t4_up_first", int'(bus.sobe), 1);
        repeat (8) tick();
        chk("t4_at2", int'({bus.andar_atual, bus.porta_aberta}), 3'b101);
        chk("t4_pend2", int'(bus.pendentes), 3'b001);
        repeat (4) tick();
        chk("t4_reverse", int'({bus.sobe, bus.desce, bus.porta_aberta}), 3'b010);
        repeat (15) tick();
        chk("t4_desce_e15", int'({bus.desce, bus.andar_atual}), 3'b101);
        tick();
        chk("t4_at0", int'({bus.desce, bus.porta_aberta, bus.andar_atual}), 4'b0100);
        chk("t4_pend0", int'(bus.pendentes), 0);

        // 5: call at the idle floor, button held to keep the door open
        do_reset();
        call_from_idle(3'b101);
        repeat (12) tick();
        chk("t5_idle1", int'({bus.andar_atual, bus.porta_aberta, bus.sobe, bus.desce}), 5'b01000);
        repeat (2) tick();
        bus.bf_n = 3'b101;
        tick();
        chk("t5_latch", int'({bus.pendentes, bus.porta_aberta}), 4'b0100);
        tick();
        chk("t5_open", int'({bus.porta_aberta, bus.sobe, bus.desce}), 3'b100);
        chk("t5_pend_clr", int'(bus.pendentes), 0);
        repeat (8) tick();
        chk("t5_held", int'(bus.porta_aberta), 1);
        bus.bf_n = '1;
        repeat (3) tick();
        chk("t5_after3", int'(bus.porta_aberta), 1);
        tick();
        chk("t5_closed", int'({bus.porta_aberta, bus.sobe, bus.desce, bus.pendentes}), 0);

        // 6: asynchronous reset between floors
        do_reset();
        call_from_idle(3'b011);
        repeat (10) tick();
        chk("t6_moving", int'({bus.sobe, bus.andar_atual}), 3'b101);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_async", int'({bus.sobe, bus.desce, bus.porta_aberta, bus.andar_atual, bus.pendentes}), 0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Randomized traffic, including held buttons and multi-press cycles
        for (int k = 0; k < 4000; k++) begin
            logic [N-1:0] bd, bf;
            bd = '1;
            bf = '1;
            if ($urandom_range(0, 9) == 0) bd[$urandom_range(0, N - 1)] = 1'b0;
            if ($urandom_range(0, 9) == 0) bf[$urandom_range(0, N - 1)] = 1'b0;
            if ($urandom_range(0, 99) == 0) bf = '0;
            if ($urandom_range(0, 3) == 0) begin
                bd = bus.bd_n;
                bf = bus.bf_n;
            end
            bus.bd_n = bd;
            bus.bf_n = bf;
            tick();
            if ($urandom_range(0, 1499) == 0) do_reset();
        end
        bus.bd_n = '1;
        bus.bf_n = '1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
